// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scan controller sharing one external hex decoder across digits.
// Optional leading-zero suppression is compiled in with `define SEG_SCAN_LZS_EN.
module seg_scan_controller #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DIV_WIDTH    = 16,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [3:0]              dec_d,
   input  logic [6:0]              dec_seg,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done,
   output logic                    pending
);

   localparam int unsigned IW = $clog2(NUM_DIGITS);
   localparam int unsigned VW = 4 * NUM_DIGITS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_SHOW  = 2'd2;

   localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(REFRESH_DIV - 1);
   localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0]        IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [1:0]            state_q, state_d;
   logic [DIV_WIDTH-1:0]  presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [VW-1:0]         act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0] act_mask_q, act_mask_d;
   logic [VW-1:0]         pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0] pend_mask_q, pend_mask_d;
   logic                  pend_q, pend_d;
   logic [3:0]            dec_d_q, dec_d_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
   logic                  frame_done_q, frame_done_d;

   logic [NUM_DIGITS-1:0] eff_blank;
   logic                  tick;
   logic                  wrap;
   logic [6:0]            lit_seg;
   logic [NUM_DIGITS-1:0] lit_en;

`ifdef SEG_SCAN_LZS_EN
   // A digit goes dark when it and every digit above it hold zero; digit 0 always shows.
   logic [NUM_DIGITS-1:0] lz_sup;
   logic                  zero_above;
   always_comb begin
      lz_sup     = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (act_val_q[4*i +: 4] == 4'h0);
         lz_sup[i]  = zero_above;
      end
   end
   assign eff_blank = act_mask_q | lz_sup;
`else
   assign eff_blank = act_mask_q;
`endif

   assign tick    = (state_q != ST_IDLE) && en && (presc_q == DIV_LAST);
   assign wrap    = tick && (state_q == ST_SHOW) && (idx_q == IDX_LAST);
   assign lit_seg = eff_blank[idx_q] ? 7'h00 : dec_seg;
   assign lit_en  = NUM_DIGITS'(1) << idx_q;

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      idx_d        = idx_q;
      act_val_d    = act_val_q;
      act_mask_d   = act_mask_q;
      pend_val_d   = pend_val_q;
      pend_mask_d  = pend_mask_q;
      pend_d       = pend_q;
      seg_d        = seg_q;
      digit_en_d   = digit_en_q;
      frame_done_d = 1'b0;

      if (state_q == ST_IDLE) begin
         presc_d    = '0;
         idx_d      = '0;
         seg_d      = 7'h00;
         digit_en_d = '0;
         if (load) begin
            act_val_d  = value;
            act_mask_d = blank_mask;
         end
         if (en) begin
            state_d = ST_BLANK;
         end
      end else if (!en) begin
         // Abort: nothing loaded is lost, it becomes the displayed value.
         state_d    = ST_IDLE;
         presc_d    = '0;
         idx_d      = '0;
         seg_d      = 7'h00;
         digit_en_d = '0;
         pend_d     = 1'b0;
         if (load) begin
            act_val_d  = value;
            act_mask_d = blank_mask;
         end else if (pend_q) begin
            act_val_d  = pend_val_q;
            act_mask_d = pend_mask_q;
         end
      end else begin
         presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
         if (state_q == ST_BLANK) begin
            seg_d      = 7'h00;
            digit_en_d = '0;
            if (presc_q == BLANK_LAST) begin
               state_d    = ST_SHOW;
               seg_d      = lit_seg;
               digit_en_d = lit_en;
            end
         end else if (tick) begin
            state_d      = ST_BLANK;
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            seg_d        = 7'h00;
            digit_en_d   = '0;
            frame_done_d = wrap;
         end else begin
            seg_d      = lit_seg;
            digit_en_d = lit_en;
         end

         if (wrap) begin
            pend_d = 1'b0;
            if (load) begin
               act_val_d  = value;
               act_mask_d = blank_mask;
            end else if (pend_q) begin
               act_val_d  = pend_val_q;
               act_mask_d = pend_mask_q;
            end
         end else if (load) begin
            pend_val_d  = value;
            pend_mask_d = blank_mask;
            pend_d      = 1'b1;
         end
      end

      // Follows idx and the active buffer so the decoder settles during the blank window.
      dec_d_d = (state_d == ST_IDLE) ? 4'h0 : act_val_d[4*int'(idx_d) +: 4];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         presc_q      <= '0;
         idx_q        <= '0;
         act_val_q    <= '0;
         act_mask_q   <= '0;
         pend_val_q   <= '0;
         pend_mask_q  <= '0;
         pend_q       <= 1'b0;
         dec_d_q      <= 4'h0;
         seg_q        <= 7'h00;
         digit_en_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         act_val_q    <= act_val_d;
         act_mask_q   <= act_mask_d;
         pend_val_q   <= pend_val_d;
         pend_mask_q  <= pend_mask_d;
         pend_q       <= pend_d;
         dec_d_q      <= dec_d_d;
         seg_q        <= seg_d;
         digit_en_q   <= digit_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign dec_d      = dec_d_q;
   assign seg_out    = seg_q;
   assign digit_en   = digit_en_q;
   assign frame_done = frame_done_q;
   assign pending    = pend_q;

endmodule
